// File: rtl/vga_pixel_gen.sv
// Pixel generator behind the VTC: two-stage colour pipeline with four test patterns
// (bars, checker, bouncing box, solid). HS/VS/BLANK_N ride the same 2-cycle delay.

module vga_box_axis #(
  parameter int LIMIT = 640,
  parameter int SIZE  = 32,
  parameter int STEP  = 2
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        tick,
  output logic [15:0] pos
);
  logic dir_pos;

  // Bounce before the far edge would cross LIMIT, or before pos would underflow.
  always_ff @(posedge clkin) begin
    if (reset) begin
      pos     <= '0;
      dir_pos <= 1'b1;
    end else if (tick) begin
      if (dir_pos) begin
        if ({1'b0, pos} + 17'(STEP + SIZE) > 17'(LIMIT)) begin
          dir_pos <= 1'b0;
          pos     <= pos - 16'(STEP);
        end else begin
          pos <= pos + 16'(STEP);
        end
      end else begin
        if (pos < 16'(STEP)) begin
          dir_pos <= 1'b1;
          pos     <= pos + 16'(STEP);
        end else begin
          pos <= pos - 16'(STEP);
        end
      end
    end
  end
endmodule

module vga_pixel_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BAR_WIDTH  = 80,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 32,
  parameter int STEP       = 2
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        activeVideo,
  input  logic [15:0] horizontalValue,
  input  logic [15:0] verticalValue,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [1:0]  mode_sel,
  input  logic [23:0] solid_color,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
);
  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
  } s1_t;

  s1_t              s1;
  logic [1:0]       vld_pipe;   // [0]=stage-1 active, [1]=BLANK_N
  logic [1:0]       mode_q;
  logic [23:0]      rgb_q;
  logic             hs_q, vs_q;
  logic             frame_tick;
  logic [1:0][15:0] box_pos;    // [0]=x, [1]=y

  logic [15:0] bar_q;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb, rgb_nxt;
  logic        chk_bit, in_box;

  assign frame_tick = (s1.v == 16'(V_ACTIVE)) && (s1.h == 16'd0);

  for (genvar g = 0; g < 2; g++) begin : g_axis
    vga_box_axis #(
      .LIMIT (g == 0 ? H_ACTIVE : V_ACTIVE),
      .SIZE  (BOX_SIZE),
      .STEP  (STEP)
    ) u_axis (
      .clkin (clkin),
      .reset (reset),
      .tick  (frame_tick),
      .pos   (box_pos[g])
    );
  end

  always_comb begin
    bar_q   = s1.h / 16'(BAR_WIDTH);
    bar_idx = (bar_q > 16'd7) ? 3'd7 : bar_q[2:0];
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    chk_bit = s1.h[CHECK_LOG2] ^ s1.v[CHECK_LOG2];
    in_box  = (s1.h >= box_pos[0]) &&
              ({1'b0, s1.h} < {1'b0, box_pos[0]} + 17'(BOX_SIZE)) &&
              (s1.v >= box_pos[1]) &&
              ({1'b0, s1.v} < {1'b0, box_pos[1]} + 17'(BOX_SIZE));
    case (mode_q)
      2'd0:    rgb_nxt = bar_rgb;
      2'd1:    rgb_nxt = chk_bit ? 24'hFFFFFF : 24'h000000;
      2'd2:    rgb_nxt = in_box ? 24'hFFFF00 : 24'h000080;
      default: rgb_nxt = solid_color;
    endcase
    if (!vld_pipe[0]) rgb_nxt = 24'h000000;
  end

  // Stage-1 syncs clear to their idle (high) level so nothing glitches out of reset.
  always_ff @(posedge clkin) begin
    if (reset) begin
      s1       <= '{h: 16'd0, v: 16'd0, hs: 1'b1, vs: 1'b1};
      vld_pipe <= '0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      mode_q   <= '0;
    end else begin
      s1       <= '{h: horizontalValue, v: verticalValue, hs: hs_in, vs: vs_in};
      vld_pipe <= {vld_pipe[0], activeVideo};
      rgb_q    <= rgb_nxt;
      hs_q     <= s1.hs;
      vs_q     <= s1.vs;
      if (frame_tick) mode_q <= mode_sel;
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = vld_pipe[1];
endmodule

// File: tb/tb_vga_pixel_gen.sv
module tb_vga_pixel_gen;
  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        activeVideo = 1'b0;
  logic [15:0] horizontalValue = '0;
  logic [15:0] verticalValue = '0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic [1:0]  mode_sel = '0;
  logic [23:0] solid_color = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;

  vga_pixel_gen dut (
    .clkin(clkin), .reset(reset), .activeVideo(activeVideo),
    .horizontalValue(horizontalValue), .verticalValue(verticalValue),
    .hs_in(hs_in), .vs_in(vs_in), .mode_sel(mode_sel), .solid_color(solid_color),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    bit        rst, act, hs, vs;
    int        h, v, msel;
    bit [23:0] solid;
    string     tag;
  } rec_t;

  typedef struct {
    bit [23:0] rgb;
    bit        hs, vs, blank_n;
    string     tag;
  } exp_t;

  exp_t exp_q[$];
  rec_t prev;
  bit   have_prev = 0;
  bit   done = 0;
  int   n_chk = 0, n_fail = 0;

  int m_mode = 0, bx = 0, by = 0;
  bit bdx = 1, bdy = 1;

  int        g_msel = 0;
  bit [23:0] g_solid = 0;
  bit        g_hs = 1, g_vs = 1;
  string     g_tag = "reset";

  function automatic bit [23:0] bar_color(int h);
    int idx;
    idx = h / 80;
    if (idx > 7) idx = 7;
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic void bounce(inout int p, inout bit d, input int lim);
    if (d) begin
      if (p + 2 + 32 > lim) begin d = 0; p = p - 2; end
      else p = p + 2;
    end else begin
      if (p < 2) begin d = 1; p = p + 2; end
      else p = p - 2;
    end
  endfunction

  function automatic void model_step(rec_t r, rec_t nx);
    exp_t e;
    e.tag = r.tag;
    if (nx.rst || r.rst) begin
      e.rgb = 0; e.hs = 1; e.vs = 1; e.blank_n = 0;
      if (nx.rst) begin
        m_mode = 0; bx = 0; by = 0; bdx = 1; bdy = 1;
      end
    end else begin
      e.hs = r.hs; e.vs = r.vs; e.blank_n = r.act;
      if (!r.act) e.rgb = 0;
      else case (m_mode)
        0: e.rgb = bar_color(r.h);
        1: e.rgb = (((r.h / 32) ^ (r.v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        2: e.rgb = (r.h >= bx && r.h < bx + 32 && r.v >= by && r.v < by + 32)
                   ? 24'hFFFF00 : 24'h000080;
        default: e.rgb = nx.solid;
      endcase
      if (r.v == 480 && r.h == 0) begin
        m_mode = nx.msel;
        bounce(bx, bdx, 640);
        bounce(by, bdy, 480);
      end
    end
    exp_q.push_back(e);
  endfunction

  task automatic pix(input int h, input int v, input bit act, input bit rst = 0);
    rec_t r;
    r.rst = rst; r.act = act; r.h = h; r.v = v; r.hs = g_hs; r.vs = g_vs;
    r.msel = g_msel; r.solid = g_solid; r.tag = g_tag;
    @(posedge clkin); #1;
    reset = rst; activeVideo = act;
    horizontalValue = 16'(h); verticalValue = 16'(v);
    hs_in = g_hs; vs_in = g_vs; mode_sel = 2'(g_msel); solid_color = g_solid;
    if (have_prev) model_step(prev, r);
    prev = r;
    have_prev = 1;
  endtask

  task automatic frame();
    pix(0, 480, 0);
    pix(1, 481, 0);
  endtask

  always @(negedge clkin) begin
    if (exp_q.size() >= 2) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if ({VGA_R, VGA_G, VGA_B} !== e.rgb || VGA_HS !== e.hs ||
          VGA_VS !== e.vs || VGA_BLANK_N !== e.blank_n) begin
        n_fail++;
        $display("FAIL %s: got rgb=%h hs=%b vs=%b blank_n=%b, want rgb=%h hs=%b vs=%b blank_n=%b",
                 e.tag, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_N,
                 e.rgb, e.hs, e.vs, e.blank_n);
      end
    end
  end

  initial begin
    #2_000_000;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: stimulus did not complete, %0d checks, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    g_tag = "reset";
    repeat (3) pix(5, 0, 1, 1);
    @(negedge clkin);
    n_chk++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000 || VGA_HS !== 1'b1 ||
        VGA_VS !== 1'b1 || VGA_BLANK_N !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rgb=%h hs=%b vs=%b blank_n=%b",
               {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_N);
    end

    g_tag = "bars";
    pix(0, 10, 1); pix(85, 10, 1); pix(639, 10, 1); pix(639, 10, 0);
    for (int h = 0; h < 700; h += 37) pix(h, 11, 1);

    g_tag = "mode_latch";
    g_msel = 1;
    pix(0, 100, 1); pix(85, 100, 1); pix(300, 479, 1); pix(639, 479, 1);
    pix(0, 480, 0);
    pix(0, 0, 1); pix(32, 0, 1); pix(40, 33, 1); pix(70, 40, 1);

    g_tag = "box";
    pix(0, 0, 0, 1);
    g_msel = 2;
    frame();
    pix(2, 2, 1); pix(1, 2, 1); pix(33, 2, 1); pix(34, 33, 1);
    for (int t = 0; t < 330; t++) begin
      frame();
      pix(bx, by, 1);
      pix(bx + 31, by + 31, 1);
      pix(bx + 32, by, 1);
      pix(bx == 0 ? 0 : bx - 1, by, 1);
      pix(bx, by + 32, 1);
      pix(bx, by == 0 ? 0 : by - 1, 1);
    end

    g_tag = "sync";
    for (int c = 0; c < 120; c++) begin
      g_hs = !(c >= 10 && c <= 105);
      g_vs = !(c >= 50 && c <= 52);
      pix(c, 200, 1);
    end
    g_hs = 1; g_vs = 1;

    g_tag = "solid";
    g_msel = 3;
    frame();
    g_solid = 24'h123456;
    repeat (6) pix($urandom_range(0, 639), $urandom_range(0, 479), 1);
    pix(10, 10, 1, 1);
    g_msel = 2;
    frame();
    pix(2, 2, 1); pix(1, 2, 1); pix(0, 0, 1); pix(33, 33, 1);

    g_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      int h, v;
      bit rst;
      rst = ($urandom_range(0, 63) == 0);
      g_msel = $urandom_range(0, 3);
      g_solid = 24'($urandom);
      g_hs = 1'($urandom);
      g_vs = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin h = 0; v = 480; end
      else begin h = $urandom_range(0, 700); v = $urandom_range(0, 520); end
      pix(h, v, 1'($urandom), rst);
    end

    g_tag = "flush";
    g_hs = 1; g_vs = 1;
    repeat (3) pix(0, 0, 0);
    @(negedge clkin);
    @(negedge clkin);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pixel_gen.md
Name: vga_pixel_gen

Overview:
Pixel-generation stage directly downstream of the VTC video timing controller. Consumes the VTC's activeVideo flag, horizontal/vertical counters and HS/VS syncs, and produces 24-bit RGB for the DE10-Standard VGA DAC. It offers four selectable test patterns, including an animated bouncing box. Syncs and blank are delayed to stay aligned with the 2-cycle colour pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BAR_WIDTH, 80, colour-bar width in pixels
CHECK_LOG2, 5, log2 of checker square size (32 px)
BOX_SIZE, 32, bouncing-box edge length in pixels
STEP, 2, box displacement per frame on each axis

Ports:
clkin  in  1  pixel clock, same clock as VTC
reset  in  1  synchronous, active-high reset
activeVideo  in  1  VTC visible-region flag
horizontalValue  in  16  VTC pixel column
verticalValue  in  16  VTC line number
hs_in  in  1  VTC VGA_HS, active low
vs_in  in  1  VTC VGA_VS, active low
mode_sel  in  2  0=bars, 1=checker, 2=box, 3=solid
solid_color  in  24  {R,G,B} for mode 3
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue
VGA_HS  out  1  delayed hs_in
VGA_VS  out  1  delayed vs_in
VGA_BLANK_N  out  1  delayed activeVideo

Behaviour:
- Clocking and reset: single clock `clkin`; reset is synchronous, active-high.
- Reset values: RGB=0; VGA_HS=1; VGA_VS=1; VGA_BLANK_N=0; both pipeline stages cleared; mode register=0; box x=0, y=0; both box directions positive.
- Reset mid-frame: outputs take their reset values at the first clkin edge with reset=1. Box and mode restart from reset state. No partial-frame recovery is required.
- Pipeline stage 1: registers activeVideo, h, v, hs_in, vs_in.
- Pipeline stage 2: computes colour from the stage-1 values; registers RGB and the delayed syncs/blank.
- Latency: exactly 2 cycles from any input to the corresponding output, for RGB, HS, VS and BLANK_N alike.
- Blanking: stage-1 active=0 forces RGB=000000, regardless of mode.
- Frame tick:
  - One-cycle pulse when stage-1 v==V_ACTIVE and h==0 (first cycle of vertical blank).
  - mode_sel is sampled into the mode register only on the tick, so mode changes never tear a frame.
  - Box position is updated on the tick.
- Mode 0, colour bars:
  - idx = h / BAR_WIDTH, clamped to 7.
  - idx 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Mode 1, checkerboard: bit0 of ((h>>CHECK_LOG2) ^ (v>>CHECK_LOG2)): 1 → FFFFFF, 0 → 000000.
- Mode 2, box:
  - Inside when x ≤ h < x+BOX_SIZE and y ≤ v < y+BOX_SIZE.
  - Inside → FFFF00; outside → 000080.
- Mode 3, solid: output solid_color as sampled in stage 2 (not frame-latched).
- Box motion, x axis, per tick (y axis identical with V_ACTIVE):
  - dir+ and x+STEP+BOX_SIZE > H_ACTIVE → dir becomes −, x -= STEP.
  - dir+ otherwise → x += STEP.
  - dir− and x < STEP → dir becomes +, x += STEP.
  - dir− otherwise → x -= STEP.
- Box range invariant: x stays within [0, H_ACTIVE−BOX_SIZE]; y stays within [0, V_ACTIVE−BOX_SIZE].
- Box state updates every tick regardless of mode.
- Arithmetic: position registers are 16 bits. Comparisons are unsigned with no overflow, since all sums are < 2^16 for the default parameters.

Test Plan:
- Reset: hold reset 3 cycles with activeVideo=1, h=5 → RGB=000000, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0; after release, box at (0,0).
- Colour bars (mode 0): inputs active with v=10 at h=0, 85, 639; then activeVideo=0 → after 2 cycles:
  - h=0 → FFFFFF; h=85 → FFFF00; h=639 → 000000.
  - activeVideo=0 → RGB=000000 and BLANK_N=0.
- Frame-latched mode change: mode_sel 0→1 at v=100 → bars persist through line 479; after tick at v=480,h=0, next frame gives h=0,v=0 → 000000 and h=32,v=0 → FFFFFF.
- Box motion and bounce: mode 2 from reset.
  - After 1 tick: box at (2,2); pixel h=2,v=2 → FFFF00; h=1,v=2 → 000080.
  - After 224 ticks y=448; tick 225 gives y=446.
  - After 304 ticks x=608; tick 305 gives x=606.
- Sync alignment: hs_in low for cycles 10–105 → VGA_HS low cycles 12–107. A vs_in pulse is likewise delayed by 2 cycles.
- Solid colour: mode 3, solid_color=123456, active region → RGB=123456. Mid-frame reset → RGB=000000 on the next edge and box returns to (0,0).
